// File: rtl/uart_tx_pkg.sv
// Shared definitions for the buffered UART transmitter: serialiser states,
// oversampling ratio and the baud-rate divisor calculation.
package uart_tx_pkg;

    localparam int unsigned OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // Rounded divisor from the system clock to one oversampling tick.
    // rate: 0=4800, 1=9600, 2=19200, 3=38400 baud.
    function automatic int unsigned baud_div(input int unsigned sys_clk, input logic [1:0] rate);
        int unsigned baud;
        baud = 32'd4800 << rate;
        return (sys_clk + (OVERSAMPLE / 2) * baud) / (OVERSAMPLE * baud);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversampling tick generator. The limit follows b_rate_i
// immediately; a counter already past a newly smaller limit wraps on the
// next clock.
module uart_baud_tick
    import uart_tx_pkg::*;
#(
    parameter int unsigned SYS_CLK = 100000000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] b_rate_i,
    output logic       s_tick_o
);

    localparam int unsigned DIV0  = baud_div(SYS_CLK, 2'd0);
    localparam int unsigned DIV1  = baud_div(SYS_CLK, 2'd1);
    localparam int unsigned DIV2  = baud_div(SYS_CLK, 2'd2);
    localparam int unsigned DIV3  = baud_div(SYS_CLK, 2'd3);
    // 4800 baud has the largest divisor, so it sizes the counter.
    localparam int unsigned CNT_W = (DIV0 > 1) ? $clog2(DIV0) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] lim;

    // Select the terminal count and compute the tick and next count.
    always_comb begin
        lim = CNT_W'(DIV0 - 1);
        case (b_rate_i)
            2'd0:    lim = CNT_W'(DIV0 - 1);
            2'd1:    lim = CNT_W'(DIV1 - 1);
            2'd2:    lim = CNT_W'(DIV2 - 1);
            default: lim = CNT_W'(DIV3 - 1);
        endcase
        s_tick_o = (cnt_q == lim);
        cnt_d    = (cnt_q >= lim) ? '0 : cnt_q + 1'b1;
    end

    // Divider counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_byte_fifo.sv
// First-word-fall-through byte FIFO. Pointers carry one extra bit so that
// equal low bits with differing MSBs mean full. Flags are registered from
// the next pointer values. A push into a full FIFO is accepted only when a
// pop happens on the same clock.
module uart_byte_fifo
    import uart_tx_pkg::*;
#(
    parameter int DBITS  = 8,
    parameter int ADDR_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_i,
    input  logic [DBITS-1:0] wdata_i,
    input  logic             rd_i,
    output logic [DBITS-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DBITS-1:0]  mem_q [DEPTH];
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              rd_en;
    logic              wr_en;

    // Qualify push/pop and derive next pointers and flags.
    always_comb begin
        rd_en    = rd_i && !empty_q;
        wr_en    = wr_i && (!full_q || rd_en);
        wr_ptr_d = wr_ptr_q + (ADDR_W + 1)'(wr_en);
        rd_ptr_d = rd_ptr_q + (ADDR_W + 1)'(rd_en);
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]) &&
                   (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]);
    end

    // Pointer and flag registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array; contents need no reset since the pointers gate them.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/uart_serialiser.sv
// Frame serialiser: start bit, DBITS data bits LSB first, SBITS stop bits,
// each bit lasting OVERSAMPLE ticks. done_o fires combinationally on the last
// stop tick so the FIFO pops on the same edge the FSM returns to IDLE.
module uart_serialiser
    import uart_tx_pkg::*;
#(
    parameter int DBITS = 8,
    parameter int SBITS = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             s_tick_i,
    input  logic             start_i,
    input  logic [DBITS-1:0] din_i,
    output logic             tx_o,
    output logic             idle_o,
    output logic             done_o
);

    localparam int unsigned STOP_TICKS = OVERSAMPLE * SBITS;
    localparam int          TCNT_W     = $clog2(STOP_TICKS);
    localparam int          BCNT_W     = (DBITS > 1) ? $clog2(DBITS) : 1;

    tx_state_e         state_q, state_d;
    logic [TCNT_W-1:0] tick_q, tick_d;
    logic [BCNT_W-1:0] bit_q, bit_d;
    logic [DBITS-1:0]  shreg_q, shreg_d;

    // Next-state, counters, shift register and line outputs.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_o    = 1'b1;
        idle_o  = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            IDLE: begin
                idle_o = 1'b1;
                if (start_i) begin
                    shreg_d = din_i;
                    tick_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                tx_o = 1'b0;
                if (s_tick_i) begin
                    if (tick_q == TCNT_W'(OVERSAMPLE - 1)) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            DATA: begin
                tx_o = shreg_q[0];
                if (s_tick_i) begin
                    if (tick_q == TCNT_W'(OVERSAMPLE - 1)) begin
                        tick_d  = '0;
                        shreg_d = shreg_q >> 1;
                        if (bit_q == BCNT_W'(DBITS - 1)) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (s_tick_i) begin
                    if (tick_q == TCNT_W'(STOP_TICKS - 1)) begin
                        done_o  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers: state and counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
        end
    end

    // Data shift register; IDLE forces the line high, so no reset needed.
    always_ff @(posedge clk_i) begin
        shreg_q <= shreg_d;
    end

endmodule

// File: rtl/uart_tx_top.sv
// Buffered UART transmitter: byte FIFO feeding the serialiser, paced by the
// baud tick generator. The serialiser pops the FIFO at the end of each frame
// and starts the next one whenever the FIFO is non-empty.
module uart_tx_top
    import uart_tx_pkg::*;
#(
    parameter int          DBITS   = 8,
    parameter int          SBITS   = 1,
    parameter int unsigned SYS_CLK = 100000000,
    parameter int          ADDR_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_uart,
    input  logic [DBITS-1:0] wr_data,
    input  logic [1:0]       b_rate,
    output logic             tx,
    output logic             tx_full,
    output logic             tx_empty,
    output logic             tx_idle,
    output logic             tx_done
);

    logic             s_tick;
    logic [DBITS-1:0] rd_data;

    uart_baud_tick #(
        .SYS_CLK (SYS_CLK)
    ) u_baud (
        .clk_i    (clk),
        .rst_ni   (rst),
        .b_rate_i (b_rate),
        .s_tick_o (s_tick)
    );

    uart_byte_fifo #(
        .DBITS  (DBITS),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .wr_i    (wr_uart),
        .wdata_i (wr_data),
        .rd_i    (tx_done),
        .rdata_o (rd_data),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    uart_serialiser #(
        .DBITS (DBITS),
        .SBITS (SBITS)
    ) u_ser (
        .clk_i    (clk),
        .rst_ni   (rst),
        .s_tick_i (s_tick),
        .start_i  (!tx_empty),
        .din_i    (rd_data),
        .tx_o     (tx),
        .idle_o   (tx_idle),
        .done_o   (tx_done)
    );

endmodule

// File: tb/tb_uart_tx_top.sv
// Self-checking bench for uart_tx_top: a frame-level reference model of the
// FIFO and serial line checked every cycle, plus literal timing checks.
module tb_uart_tx_top;

    localparam int SYS_CLK_TB = 1228800;   // divisors 16/8/4/2
    localparam int TOTAL      = 16 * (1 + 8 + 1);

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_uart = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [1:0] b_rate = 2'b11;
    logic [1:0] rate100 = 2'b01;
    logic       tx, tx_full, tx_empty, tx_idle, tx_done;
    logic       tx_b, full_b, empty_b, idle_b, done_b;

    always #5 clk = ~clk;

    uart_tx_top #(.DBITS(8), .SBITS(1), .SYS_CLK(SYS_CLK_TB), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .wr_uart(wr_uart), .wr_data(wr_data), .b_rate(b_rate),
        .tx(tx), .tx_full(tx_full), .tx_empty(tx_empty), .tx_idle(tx_idle), .tx_done(tx_done)
    );

    uart_tx_top dut100 (
        .clk(clk), .rst(rst), .wr_uart(1'b0), .wr_data(8'h00), .b_rate(rate100),
        .tx(tx_b), .tx_full(full_b), .tx_empty(empty_b), .tx_idle(idle_b), .tx_done(done_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int div_of(input logic [1:0] r);
        int baud;
        baud = 4800 << r;
        return (SYS_CLK_TB + 8 * baud) / (16 * baud);
    endfunction

    // Reference model state
    logic [7:0] q[$];
    bit         busy = 1'b0;
    int         kt = 0;
    logic [7:0] frame = 8'h00;
    int         n = 0;
    int         D = 2;
    bit         model_en = 1'b0;
    int         done_cnt = 0;

    // Compare DUT against the model mid-cycle, then advance the model one edge.
    always @(negedge clk) begin : cmp
        bit   tick_now, exp_done, start, pop, push;
        logic exp_tx;
        int   seg;
        if (model_en) begin
            tick_now = ((n % D) == D - 1);
            exp_tx   = 1'b1;
            exp_done = 1'b0;
            if (busy) begin
                seg = kt / 16;
                if (seg == 0)      exp_tx = 1'b0;
                else if (seg <= 8) exp_tx = frame[3'(seg - 1)];
                else               exp_tx = 1'b1;
                exp_done = tick_now && (kt == TOTAL - 1);
            end
            check("tx", 32'(tx), 32'(exp_tx));
            check("tx_idle", 32'(tx_idle), 32'(!busy));
            check("tx_done", 32'(tx_done), 32'(exp_done));
            check("tx_empty", 32'(tx_empty), 32'(q.size() == 0));
            check("tx_full", 32'(tx_full), 32'(q.size() == 16));
            if (tx_done === 1'b1) done_cnt++;
            start = !busy && (q.size() != 0);
            pop   = exp_done;
            push  = wr_uart && ((q.size() < 16) || pop);
            if (busy && tick_now) kt++;
            if (pop) begin
                busy = 1'b0;
                void'(q.pop_front());
            end
            if (push) q.push_back(wr_data);
            if (start) begin
                busy  = 1'b1;
                kt    = 0;
                frame = q[0];
            end
            n++;
        end
    end

    task automatic do_reset(input logic [1:0] r);
        model_en = 1'b0;
        wr_uart  = 1'b0;
        b_rate   = r;
        @(posedge clk);
        #1 rst = 1'b0;
        #2;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_idle", 32'(tx_idle), 32'd1);
        check("rst_empty", 32'(tx_empty), 32'd1);
        check("rst_full", 32'(tx_full), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("rst_no_tick", 32'(dut.s_tick), 32'd0);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        q.delete();
        busy = 1'b0;
        kt = 0;
        n = 0;
        D = div_of(r);
        model_en = 1'b1;
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_uart = 1'b1;
        wr_data = d;
        @(posedge clk);
        #1 wr_uart = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int c;
        c = 0;
        while ((busy || q.size() != 0) && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(name, 32'(c < budget), 32'd1);
    endtask

    task automatic measure_period(output int p);
        int c;
        c = 0;
        while (dut100.s_tick !== 1'b1 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        p = 0;
        do begin
            @(negedge clk);
            p++;
        end while (dut100.s_tick !== 1'b1 && p < 3000);
    endtask

    initial begin : stim
        int c, hi, d0, p, run, maxrun, guard;
        bit started, saw_full;
        int exp_bits[8];
        exp_bits = '{0, 1, 0, 0, 1, 0, 1, 1};

        // 0xA5 at 9600 baud: bit time 16*8 clocks
        do_reset(2'b01);
        d0 = done_cnt;
        write_byte(8'hA5);
        c = 0;
        while (tx !== 1'b0 && c < 200) begin @(negedge clk); c++; end
        check("a5_start_seen", 32'(c < 200), 32'd1);
        c = 0;
        while (tx !== 1'b1 && c < 200) begin @(negedge clk); c++; end
        check("a5_start_len_ok", 32'(c <= 128), 32'd1);
        hi = 0;
        while (tx === 1'b1 && hi < 300) begin @(negedge clk); hi++; end
        check("a5_bit0_len", 32'(hi), 32'd128);
        repeat (64) @(negedge clk);
        check("a5_bit1", 32'(tx), 32'(exp_bits[0]));
        for (int i = 1; i < 8; i++) begin
            repeat (128) @(negedge clk);
            check($sformatf("a5_bit%0d", i + 1), 32'(tx), 32'(exp_bits[i]));
        end
        repeat (200) @(negedge clk);
        check("a5_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("a5_empty_after", 32'(tx_empty), 32'd1);
        check("a5_idle_after", 32'(tx_idle), 32'd1);

        // Tick periods at 100 MHz
        measure_period(p);
        check("tick_period_9600", 32'(p), 32'd651);
        @(posedge clk);
        #1 rate100 = 2'b11;
        measure_period(p);
        measure_period(p);
        check("tick_period_38400", 32'(p), 32'd163);

        // Three back-to-back frames at 38400
        do_reset(2'b11);
        d0 = done_cnt;
        wr_uart = 1'b1;
        wr_data = 8'h3C; @(posedge clk); #1;
        wr_data = 8'h00; @(posedge clk); #1;
        wr_data = 8'hFF; @(posedge clk); #1;
        wr_uart = 1'b0;
        run = 0; maxrun = 0; started = 1'b0; c = 0;
        while ((done_cnt - d0) < 3 && c < 2000) begin
            @(negedge clk);
            c++;
            if (tx_idle === 1'b0) started = 1'b1;
            if (started && tx_idle === 1'b1) run++;
            else run = 0;
            if (run > maxrun) maxrun = run;
        end
        check("b2b_done_pulses", 32'(done_cnt - d0), 32'd3);
        check("b2b_max_idle_gap", 32'(maxrun), 32'd1);
        wait_drain(2000, "b2b_drain");

        // 32 random bytes, skipping while full
        @(posedge clk); #1;
        saw_full = 1'b0;
        for (int i = 0; i < 32; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            guard = 0;
            while (tx_full === 1'b1 && guard < 5000) begin
                saw_full = 1'b1;
                @(posedge clk); #1;
                guard++;
            end
            write_byte(8'($urandom));
        end
        check("rand_saw_full", 32'(saw_full), 32'd1);

        // Hold the write strobe through full, including pops while full
        wr_uart = 1'b1;
        for (int i = 0; i < 700; i++) begin
            wr_data = 8'($urandom);
            @(posedge clk); #1;
        end
        wr_uart = 1'b0;
        wait_drain(9000, "rand_drain");

        // Reset in the middle of a frame
        @(posedge clk); #1;
        write_byte(8'h81);
        write_byte(8'h7E);
        repeat (60) @(posedge clk);
        #1;
        check("midframe_busy", 32'(tx_idle), 32'd0);
        do_reset(2'b11);
        repeat (20) @(negedge clk);
        check("post_reset_idle", 32'(tx_idle), 32'd1);

        model_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
